wb_vram_slave: RTL and testbench
================================

// Module: wb_vram_slave
// PURPOSE
// Wishbone classic-cycle responder fronting an on-chip word-addressed RAM.
// - Terminates bus cycles issued by the bus masters (video cache fetch, CPU data port) with ack/err/rty.
// - Provides byte-lane writes; serves as the frame/scratch store behind the interconnect.
// PARAMETERS
// ADDR_BASE   32'h0000_0000  byte address of word 0; must be aligned to 4*2**DEPTH_LOG2
// DEPTH_LOG2  10             log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB)
// PORTS
// wb_clk_i   in   1   sole clock; all logic on rising edge
// wb_rst_i   in   1   reset, asynchronous, active-high
// wb_cyc_i   in   1   cycle valid from master
// wb_stb_i   in   1   strobe; transfer request while wb_cyc_i=1
// wb_we_i    in   1   1=write, 0=read
// wb_adr_i   in   32  byte address
// wb_sel_i   in   4   byte lane enables; bit n covers dat[8n+7:8n]
// wb_dat_i   in   32  write data
// busy_i     in   1   external hold-off (e.g. scan-out owns RAM); forces retry
// wb_dat_o   out  32  read data; valid only while wb_ack_o=1 on a read
// wb_ack_o   out  1   normal termination, one-cycle pulse
// wb_err_o   out  1   error termination, one-cycle pulse
// wb_rty_o   out  1   retry termination, one-cycle pulse
// BEHAVIOUR
// - Reset (async, wb_rst_i=1): state=IDLE, wb_ack_o=wb_err_o=wb_rty_o=0, wb_dat_o=0. RAM contents are not reset.
// - FSM states: IDLE, WR, RD1, RD2, TERM.
// - IDLE: a request is sampled at edge E0 when wb_cyc_i & wb_stb_i.
//   - Bad address -> TERM with err. Bad means adr[1:0]!=0, or adr outside [ADDR_BASE, ADDR_BASE+4*2**DEPTH_LOG2).
//   - Otherwise busy_i=1 -> TERM with rty. Priority is err > rty; no RAM access is made.
//   - Otherwise wb_we_i=1 -> WR; wb_we_i=0 -> RD1. Address/sel/data/we are captured at E0.
// - WR: at E1, if wb_cyc_i & wb_stb_i, write the enabled lanes and set ack; go TERM.
//   - sel=4'b0000 still acks and writes nothing.
// - RD1: RAM address was presented at E0; RAM output is valid after E1; go RD2.
// - RD2: at E2, register the RAM word into wb_dat_o and set ack; go TERM.
// - Latency from E0 to termination: write/err/rty visible after E1 (1 wait state); read ack after E2 (2 wait states).
// - TERM: exactly one termination output is high for exactly one cycle. All three clear at the next edge; state -> IDLE.
//   - A strobe still high in IDLE is treated as a NEW request (back-to-back block cycles). Never double-acks one request.
// - Abort: wb_cyc_i=0 or wb_stb_i=0 in WR/RD1/RD2 -> IDLE, no termination, no RAM write. Any read already in flight is discarded.
// - busy_i is sampled only in IDLE; changes mid-transfer have no effect.
// - Address index = (adr - ADDR_BASE) >> 2, truncated to DEPTH_LOG2 bits; the range check guarantees no wrap.
// - wb_dat_o holds its last value outside ack. Masters must not rely on it then.
// - Reset asserted mid-transfer: outputs clear immediately. A write not yet committed at E1 is lost.
// STRUCTURE
// - Shared package wb_pkg: state encoding localparams, WB_AW=32, WB_DW=32, WB_SW=4.
// - One sub-module, vram_bytelane_ram: single-port synchronous RAM, 1-cycle read latency, 4 byte write enables.
//   Parameterised by DEPTH_LOG2; infers block RAM.
// - Top level holds the FSM, range/alignment decode and output registers.
// TESTING
// - Write adr=ADDR_BASE+8, sel=F, dat=DEADBEEF; then read it -> write ack 1 cycle after sample; read ack after 2 cycles, dat=DEADBEEF.
// - Write sel=4'b0010 dat=0000AA00 over 11223344, then read -> 1122AA44.
// - Read adr=ADDR_BASE+4*1024 (DEPTH_LOG2=10) and adr=ADDR_BASE+2 -> err one cycle each; no ack; RAM unchanged.
// - busy_i=1 at sample -> rty pulse. Retry with busy_i=0 -> normal ack. busy_i rising in RD1 -> read still acks.
// - Hold stb for 4 consecutive reads -> exactly 4 ack pulses, each separated by the wait states. Addresses 0,4,8,C return their stored words.
// - Drop wb_cyc_i in WR -> no ack, location unchanged. Assert wb_rst_i in RD2 -> ack never rises, dat_o=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone widths plus the state and response encodings for the VRAM responder.
package wb_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWr   = 3'd1,
    StRd1  = 3'd2,
    StRd2  = 3'd3,
    StTerm = 3'd4
  } state_e;

  // Which termination a request in the one-wait-state slot will receive.
  typedef enum logic [1:0] {
    RespAck = 2'd0,
    RespErr = 2'd1,
    RespRty = 2'd2
  } resp_e;

endpackage

// File: rtl/vram_bytelane_ram.sv
// Single-port synchronous RAM with four byte write enables and one-cycle read latency.
module vram_bytelane_ram #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_vram_slave.sv
// Wishbone classic-cycle responder in front of a byte-lane RAM: decode, FSM and
// registered ack/err/rty terminations.
module wb_vram_slave
  import wb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [WB_AW-1:0] wb_adr_i,
  input  logic [WB_SW-1:0] wb_sel_i,
  input  logic [WB_DW-1:0] wb_dat_i,
  input  logic             busy_i,
  output logic [WB_DW-1:0] wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o
);

  localparam logic [WB_AW:0] AddrLimit = {1'b0, ADDR_BASE} + ((WB_AW+1)'(4) << DEPTH_LOG2);

  state_e                state_q, state_d;
  resp_e                 resp_q, resp_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [WB_SW-1:0]      sel_q, sel_d;
  logic [WB_DW-1:0]      wdat_q, wdat_d;
  logic [WB_DW-1:0]      rdat_q, rdat_d;
  logic                  ack_q, ack_d, err_q, err_d, rty_q, rty_d;

  logic                  req;
  logic                  addr_ok;
  logic [WB_SW-1:0]      ram_be;
  logic [WB_DW-1:0]      ram_rdata;

  assign req     = wb_cyc_i & wb_stb_i;
  assign addr_ok = (wb_adr_i[1:0] == 2'b00) && (wb_adr_i >= ADDR_BASE) &&
                   ({1'b0, wb_adr_i} < AddrLimit);

  // RAM always follows the captured index; a read issued at the sample edge is
  // valid after the following edge and is still stable when RD2 registers it.
  vram_bytelane_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (wb_clk_i),
    .addr  (idx_q),
    .be    (ram_be),
    .wdata (wdat_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      resp_q  <= RespAck;
      idx_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    ram_be  = '0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          idx_d  = DEPTH_LOG2'((wb_adr_i - ADDR_BASE) >> 2);
          sel_d  = wb_sel_i;
          wdat_d = wb_dat_i;
          // Error and retry share the write's single wait state.
          if (!addr_ok) begin
            resp_d  = RespErr;
            state_d = StWr;
          end else if (busy_i) begin
            resp_d  = RespRty;
            state_d = StWr;
          end else if (wb_we_i) begin
            resp_d  = RespAck;
            state_d = StWr;
          end else begin
            resp_d  = RespAck;
            state_d = StRd1;
          end
        end
      end
      StWr: begin
        if (req) begin
          unique case (resp_q)
            RespErr: err_d = 1'b1;
            RespRty: rty_d = 1'b1;
            default: begin
              ram_be = sel_q;
              ack_d  = 1'b1;
            end
          endcase
          state_d = StTerm;
        end else begin
          state_d = StIdle;
        end
      end
      StRd1: state_d = req ? StRd2 : StIdle;
      StRd2: begin
        if (req) begin
          rdat_d  = ram_rdata;
          ack_d   = 1'b1;
          state_d = StTerm;
        end else begin
          state_d = StIdle;
        end
      end
      StTerm:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = rty_q;

endmodule

// File: tb/tb_wb_vram_slave.sv
// Self-checking bench for wb_vram_slave: directed scenarios plus random traffic
// against a word-array model of the RAM and the bus termination rules.
module tb_wb_vram_slave;

  localparam logic [31:0] Base  = 32'h0001_0000;
  localparam int          Words = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, busy = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_o;
  logic        ack, err, rty;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [Words];

  wb_vram_slave #(
    .ADDR_BASE  (Base),
    .DEPTH_LOG2 (10)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_sel_i (sel),
    .wb_dat_i (wdat),
    .busy_i   (busy),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 0 none, 1 ack, 2 err, 3 rty, 4 several at once
  function automatic int term_kind();
    int n;
    n = int'(ack) + int'(err) + int'(rty);
    if (n > 1) return 4;
    if (ack) return 1;
    if (err) return 2;
    if (rty) return 3;
    return 0;
  endfunction

  function automatic int exp_kind(input logic [31:0] a, input bit b);
    if (a[1:0] != 2'b00 || a < Base || a >= Base + 32'(4 * Words)) return 2;
    if (b) return 3;
    return 1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Drives one request, waits (bounded) for its termination, then releases the bus.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit b,
                      output int kind, output int lat, output logic [31:0] rd,
                      output int linger);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d; busy = b;
    kind = 0; lat = 0; rd = '0;
    while (kind == 0 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      kind = term_kind();
      rd = dat_o;
    end
    cyc = 1'b0; stb = 1'b0; busy = 1'b0;
    @(posedge clk); #1;
    linger = term_kind();
  endtask

  task automatic op(input string tag, input bit w, input logic [31:0] a,
                    input logic [3:0] s, input logic [31:0] d, input bit b);
    int kind, lat, linger, ek, el;
    logic [31:0] rd;
    ek = exp_kind(a, b);
    el = (ek == 1 && !w) ? 3 : 2;
    xfer(w, a, s, d, b, kind, lat, rd, linger);
    chk({tag, "_kind"}, 32'(kind), 32'(ek));
    chk({tag, "_lat"}, 32'(lat), 32'(el));
    chk({tag, "_pulse"}, 32'(linger), 32'd0);
    if (ek == 1 && !w) chk({tag, "_data"}, rd, model[(a - Base) >> 2]);
    if (ek == 1 && w) model[(a - Base) >> 2] = merge(model[(a - Base) >> 2], d, s);
  endtask

  initial begin
    int acks, last, cnt, kind, lat, linger;
    logic [31:0] rd, a;

    #2;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rty", {31'd0, rty}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < Words; i++) begin
      model[i] = 'x;
      op("fill", 1'b1, Base + 32'(4 * i), 4'hF, $urandom, 1'b0);
    end

    op("wr_beef", 1'b1, Base + 32'h8, 4'hF, 32'hDEAD_BEEF, 1'b0);
    op("rd_beef", 1'b0, Base + 32'h8, 4'hF, 32'h0, 1'b0);
    chk("beef_model", model[2], 32'hDEAD_BEEF);

    op("wr_full", 1'b1, Base + 32'h10, 4'hF, 32'h1122_3344, 1'b0);
    op("wr_lane", 1'b1, Base + 32'h10, 4'b0010, 32'h0000_AA00, 1'b0);
    op("rd_lane", 1'b0, Base + 32'h10, 4'hF, 32'h0, 1'b0);
    chk("lane_model", model[4], 32'h1122_AA44);
    op("wr_sel0", 1'b1, Base + 32'h10, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    op("rd_sel0", 1'b0, Base + 32'h10, 4'hF, 32'h0, 1'b0);

    op("err_top", 1'b0, Base + 32'h1000, 4'hF, 32'h0, 1'b0);
    op("err_mis", 1'b0, Base + 32'h2, 4'hF, 32'h0, 1'b0);
    op("err_low", 1'b1, Base - 32'h4, 4'hF, 32'h5555_5555, 1'b0);
    op("err_wmis", 1'b1, Base + 32'h11, 4'hF, 32'h5555_5555, 1'b1);
    op("rd_after_err", 1'b0, Base + 32'h0, 4'hF, 32'h0, 1'b0);

    op("rty", 1'b0, Base + 32'h8, 4'hF, 32'h0, 1'b1);
    op("rty_wr", 1'b1, Base + 32'h8, 4'hF, 32'h0BAD_0BAD, 1'b1);
    op("retry_ok", 1'b0, Base + 32'h8, 4'hF, 32'h0, 1'b0);

    // busy rising after the sample edge must not disturb the read
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = Base + 32'h8; sel = 4'hF;
    @(posedge clk);
    @(negedge clk); busy = 1'b1;
    kind = 0; lat = 1;
    while (kind == 0 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      kind = term_kind();
      rd = dat_o;
    end
    cyc = 1'b0; stb = 1'b0; busy = 1'b0;
    chk("busy_mid_kind", 32'(kind), 32'd1);
    chk("busy_mid_lat", 32'(lat), 32'd3);
    chk("busy_mid_data", rd, model[2]);
    @(posedge clk); #1;

    // strobe held across four reads
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = Base; sel = 4'hF;
    acks = 0; last = 0; cnt = 0;
    while (acks < 4 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (ack) begin
        chk("b2b_data", dat_o, model[acks]);
        if (acks > 0) chk("b2b_gap", 32'(cnt - last), 32'd4);
        last = cnt;
        acks++;
        adr = Base + 32'(4 * acks);
        if (acks == 4) begin
          cyc = 1'b0; stb = 1'b0;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    chk("b2b_count", 32'(acks), 32'd4);

    // cycle dropped during the write wait state
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = Base + 32'h20; sel = 4'hF; wdat = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    linger = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (term_kind() != 0) linger++;
    end
    chk("abort_noterm", 32'(linger), 32'd0);
    op("abort_rd", 1'b0, Base + 32'h20, 4'hF, 32'h0, 1'b0);

    // reset while the read sits in RD2
    op("pre_rst_rd", 1'b0, Base + 32'h8, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = Base + 32'h8; sel = 4'hF;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rd2_noack", {31'd0, ack}, 32'd0);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst_mid_ack", {31'd0, ack}, 32'd0);
    chk("rst_mid_dat", dat_o, 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk); rst = 1'b0;
    linger = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (term_kind() != 0) linger++;
    end
    chk("rst_after", 32'(linger), 32'd0);

    for (int i = 0; i < 200; i++) begin
      a = Base + 32'(4 * $urandom_range(Words - 1));
      case ($urandom_range(9))
        0: a = a + 32'($urandom_range(3, 1));
        1: a = Base + 32'h1000 + 32'(4 * $urandom_range(255));
        2: a = Base - 32'(4 * $urandom_range(64, 1));
        default: ;
      endcase
      op("rand", 1'($urandom_range(1)), a, 4'($urandom), $urandom, $urandom_range(7) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
